// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle 16-bit shift controller stepping a 1-bit shifter once per clock.
// Optional SHIFT_SEQ_EARLY_EXIT_EN finishes as soon as further steps cannot change out.
module shift_sequencer #(
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [15:0]      ain,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  output logic [15:0]      out,
  output logic             busy,
  output logic             done,
  output logic             zero
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] out_q, out_d;
  logic [1:0] op_q, op_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic zero_q;
  logic fix_in, fix_cur;
  function automatic logic [15:0] step(input logic [15:0] v, input logic [1:0] o);
    return o == 2'b01 ? {v[14:0], 1'b0} :
           o == 2'b10 ? {1'b0, v[15:1]} :
           o == 2'b11 ? {v[15], v[15:1]} : v;
  endfunction
  // Values that every further step of this op leaves unchanged.
  function automatic logic fixed(input logic [15:0] v, input logic [1:0] o);
    return v == 16'h0000 || (o == 2'b11 && v == 16'hFFFF);
  endfunction
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  assign fix_in  = fixed(ain, op);
  assign fix_cur = fixed(out_q, op_q);
`else
  assign fix_in  = 1'b0;
  assign fix_cur = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        out_d   = ain;
        op_d    = op;
        cnt_d   = amount;
        state_d = (amount == '0 || op == 2'b00 || fix_in) ? DONE : SHIFT;
      end
      SHIFT: if (fix_cur) state_d = DONE;
      else begin
        out_d   = step(out_q, op_q);
        cnt_d   = cnt_q - AMT_W'(1);
        state_d = cnt_q == AMT_W'(1) ? DONE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      zero_q  <= out_d == 16'h0000;
    end
  end
  assign out  = out_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign zero = zero_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed self-checking bench for shift_sequencer.
module tb_shift_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [15:0] ain = '0;
  logic [1:0] op = '0;
  logic [3:0] amount = '0;
  logic [15:0] out;
  logic busy, done, zero;
  int checks = 0;
  int failures = 0;
  shift_sequencer #(.AMT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ain(ain), .op(op),
    .amount(amount), .out(out), .busy(busy), .done(done), .zero(zero)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic accept(input logic [15:0] a, input logic [1:0] o, input logic [3:0] n);
    start = 1'b1; ain = a; op = o; amount = n;
    tick();
    start = 1'b0;
  endtask
  task automatic run(input string tag, input logic [15:0] a, input logic [1:0] o,
                     input logic [3:0] n, input logic [15:0] exp_out, input int exp_n);
    int e;
    accept(a, o, n);
    e = 0;
    while (!done && e < 40) begin
      check({tag, "_busy"}, busy, 1'b1);
      tick();
      e++;
    end
    check({tag, "_lat"}, e, exp_n);
    check({tag, "_out"}, out, exp_out);
    check({tag, "_zero"}, zero, exp_out == 16'h0000);
    tick();
    check({tag, "_done_pulse"}, {busy, done}, 2'b00);
    check({tag, "_hold"}, out, exp_out);
  endtask
  initial begin
    tick();
    tick();
    check("rst_out", out, 16'h0000);
    check("rst_flags", {busy, done, zero}, 3'b001);
    reset_n = 1'b1;
    tick();
    check("idle_flags", {busy, done, zero}, 3'b001);
    run("lsl1x4", 16'h0001, 2'b01, 4'd4, 16'h0010, 4);
    run("asr8000x3", 16'h8000, 2'b11, 4'd3, 16'hF000, 3);
    run("lsr8000x15", 16'h8000, 2'b10, 4'd15, 16'h0001, 15);
    run("lsr_amt0", 16'h1234, 2'b10, 4'd0, 16'h1234, 0);
    run("none_x7", 16'h1234, 2'b00, 4'd7, 16'h1234, 0);
    run("lsl7001x1", 16'h7001, 2'b01, 4'd1, 16'hE002, 1);
    run("asr4000x2", 16'h4000, 2'b11, 4'd2, 16'h1000, 2);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    run("lsr3x15", 16'h0003, 2'b10, 4'd15, 16'h0000, 3);
    run("asrffff", 16'hFFFF, 2'b11, 4'd5, 16'hFFFF, 0);
    run("lsl0x5", 16'h0000, 2'b01, 4'd5, 16'h0000, 0);
`else
    run("lsr3x15", 16'h0003, 2'b10, 4'd15, 16'h0000, 15);
    run("asrffff", 16'hFFFF, 2'b11, 4'd5, 16'hFFFF, 5);
    run("lsl0x5", 16'h0000, 2'b01, 4'd5, 16'h0000, 5);
`endif
    // start pulses while busy must be ignored
    accept(16'h00FF, 2'b01, 4'd8);
    for (int e = 1; e <= 8; e++) begin
      if (e == 2 || e == 5) begin
        start = 1'b1; ain = 16'hFFFF; op = 2'b10; amount = 4'd1;
      end
      check("ign_done_early", done, 1'b0);
      tick();
      start = 1'b0;
    end
    check("ign_done", done, 1'b1);
    check("ign_out", out, 16'hFF00);
    tick();
    check("ign_no_requeue", {busy, done}, 2'b00);
    check("ign_hold", out, 16'hFF00);
    // reset mid-operation
    accept(16'h0001, 2'b01, 4'd10);
    tick();
    tick();
    check("mid_busy", busy, 1'b1);
    reset_n = 1'b0;
    tick();
    check("mrst_out", out, 16'h0000);
    check("mrst_flags", {busy, done, zero}, 3'b001);
    reset_n = 1'b1;
    for (int e = 0; e < 12; e++) begin
      check("mrst_no_done", {busy, done}, 2'b00);
      tick();
    end
    run("post_rst", 16'h0003, 2'b01, 4'd2, 16'h000C, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift controller for the 16-bit datapath shifter. It accepts a shift operation (no-shift, LSL, LSR or ASR) with a 4-bit shift amount. It then drives a single internal 1-bit shifter instance once per clock until the requested amount is applied. The block sits between the instruction decode/FSM and the ALU operand path, giving the datapath shifts of 0–15 positions without a barrel shifter.

## Interface
- Parameters:
  - `AMT_W`, default 4: shift-amount width; maximum shift is 2^AMT_W − 1.
- Clock and reset are decided: one clock, `clk`; reset `reset_n` is synchronous and active-low.
- Ports:
  - `clk` input 1: single clock; all state updates on the rising edge.
  - `reset_n` input 1: synchronous, active-low reset.
  - `start` input 1: request; sampled only in IDLE.
  - `ain` input 16: operand, captured when `start` is accepted.
  - `op` input 2: shift operation, captured on accept.
    - 00 = none
    - 01 = LSL 1 per step, zero fill
    - 10 = LSR 1 per step, zero fill
    - 11 = ASR 1 per step, MSB copied
  - `amount` input AMT_W: number of 1-bit steps, captured on accept.
  - `out` output 16: result register; holds its value until the next accept.
  - `busy` output 1: high whenever state ≠ IDLE.
  - `done` output 1: one-cycle pulse; `out` is final while `done` = 1.
  - `zero` output 1: registered flag, `out` == 16'h0000, updated with `out`.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, with `start` = 1:
  - Load `out` ← `ain`, the op register ← `op`, and `cnt` ← `amount`.
  - If `amount` == 0 or `op` == 00, go to DONE; otherwise go to SHIFT.
- IDLE, with `start` = 0: stay in IDLE; `out` holds.
- SHIFT, every edge:
  - `out` ← shifter(`out`, op); `cnt` ← `cnt` − 1.
  - When `cnt` == 1 at the edge, go to DONE; otherwise stay in SHIFT.
- DONE: `done` = 1 for exactly one cycle, then unconditional return to IDLE.
- `start` asserted while `busy` = 1 is ignored; it is not queued. The requester must re-assert it in IDLE.
- Step arithmetic, per edge:
  - LSL: `out`[15:1] ← `out`[14:0], `out`[0] ← 0.
  - LSR: `out`[14:0] ← `out`[15:1], `out`[15] ← 0.
  - ASR: as LSR but `out`[15] is kept.
- `cnt` never underflows: SHIFT is never entered with `cnt` == 0.
- `zero` is registered from the next-state value of `out` on every edge where `out` changes, so it always matches `out`.

## Timing
- Reset (`reset_n` = 0 at an edge): state IDLE, `out` = 0, `cnt` = 0, `busy` = 0, `done` = 0, `zero` = 1.
- Reset mid-operation: the operation is abandoned in the same edge; no `done` pulse follows.
- Latency: with accept at edge 0, `done` is high in the cycle after edge N, where N = the effective step count. N = 0 puts `done` right after edge 0.
- `busy` rises after edge 0 and falls after the edge that leaves DONE.
- Back-to-back throughput: one operation per N + 2 cycles.
- `start` has no combinational path to any output; all outputs are registered.

## Configuration
- Macro: `SHIFT_SEQ_EARLY_EXIT_EN`.
- Defined: the block finishes early when further steps cannot change `out`.
  - Fixed point: `out` == 0 for LSL/LSR; `out` == 16'h0000 or 16'hFFFF for ASR.
  - In IDLE, an accept whose `ain` is already a fixed point for `op` goes straight to DONE.
  - In SHIFT, an edge whose current `out` is a fixed point goes to DONE without shifting.
  - `out` values are identical to the non-early-exit build; only latency and `busy` duration shrink.
- Not defined: every operation takes exactly `amount` steps (0 for `op` == 00).

## Test plan
- LSL 16'h0001 by 4, accept at edge 0 -> `out` = 16'h0010, `done` high only after edge 4, `zero` = 0.
- ASR 16'h8000 by 3 -> `out` = 16'hF000. LSR 16'h8000 by 15 -> `out` = 16'h0001.
- LSR 16'h1234 with `amount` = 0, and separately `op` = 00 with `amount` = 7 -> `out` = 16'h1234, `done` after edge 0, `busy` high for 1 cycle.
- Accept LSL 16'h00FF by 8, pulse `start` with new operands at edges 2 and 5 -> both ignored; `out` = 16'hFF00; the next accept happens only in IDLE.
- Accept LSL by 10, drive `reset_n` low at edge 3 -> `out` = 0, `busy` = 0, `zero` = 1, no `done` pulse; a new op accepted after reset completes normally.
- With `SHIFT_SEQ_EARLY_EXIT_EN`: LSR 16'h0003 by 15 -> `out` = 0 with `done` after edge 3. Without the macro -> same `out`, `done` after edge 15.
